// File: rtl/uart_bus_master_if.sv
// CSR port between the UART bus master and the UART peripheral register block.
// The master issues one request at a time (w_en or r_en) and holds addr/w_data
// until the slave answers with ready (optionally flagged by slverr).
interface uart_bus_master_if;
  logic        w_en;
  logic        r_en;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        ready;
  logic        slverr;

  modport master (
    output w_en,
    output r_en,
    output addr,
    output w_data,
    input  r_data,
    input  ready,
    input  slverr
  );

  modport slave (
    input  w_en,
    input  r_en,
    input  addr,
    input  w_data,
    output r_data,
    output ready,
    output slverr
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART bus master: after reset it writes the UART config register once. It then
// forwards host TX bytes to the TX data register and, while the UART raises its
// RX interrupt, drains one RX byte at a time to the host.
// Every request is bounded by a timeout. slverr and timeout events are counted
// in a saturating error counter.
module uart_bus_master #(
  parameter logic [31:0] CFG_ADDR  = 32'h0000_0000,
  parameter logic [31:0] TX_ADDR   = 32'h0000_0004,
  parameter logic [31:0] RX_ADDR   = 32'h0000_0008,
  parameter logic [31:0] CFG_VALUE = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  // host TX byte stream
  input  logic [7:0]               tx_byte,
  input  logic                     tx_byte_valid,
  output logic                     tx_byte_ready,
  // host RX byte stream
  output logic [7:0]               rx_byte,
  output logic                     rx_byte_valid,
  input  logic                     rx_byte_ready,
  // UART RX threshold / RX-full level
  input  logic                     interupt,
  // status
  output logic                     cfg_done,
  output logic [7:0]               err_cnt,
  // CSR bus toward the UART
  uart_bus_master_if.master        csr
);

  typedef enum logic [1:0] {
    CFG,
    IDLE,
    TX_REQ,
    RX_REQ
  } state_t;

  // Wide enough to count 0 .. TIMEOUT-1 (TIMEOUT is at least 2).
  localparam int unsigned        TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo;
  // tx_hold keeps the host byte from acceptance until the UART takes it.
  // tx_pend marks that tx_hold carries such a byte.
  logic [7:0]       tx_hold;
  logic             tx_pend;
  logic             tmo_hit;

  // The request ends without ready on this cycle.
  assign tmo_hit = (tmo == TMO_LAST);

  // Only the low byte of read data is meaningful to this master.
  logic unused_r_data_hi;
  assign unused_r_data_hi = ^csr.r_data[31:8];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Request sequencer: config write, TX writes, RX reads, error accounting.
  // NOTE: state is updated with non-blocking assignments only, so every branch
  // reads the values registered at the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: there is no memory array in this block, so every register gets an
      // async reset, including the byte holder.
      state         <= CFG;
      tmo           <= '0;
      tx_hold       <= 8'h00;
      tx_pend       <= 1'b0;
      csr.w_en      <= 1'b0;
      csr.r_en      <= 1'b0;
      csr.addr      <= 32'h0;
      csr.w_data    <= 32'h0;
      tx_byte_ready <= 1'b0;
      rx_byte       <= 8'h00;
      rx_byte_valid <= 1'b0;
      cfg_done      <= 1'b0;
      err_cnt       <= 8'h00;
    end else begin
      // The host takes the RX byte. A new read can only start from IDLE
      // after this flag is clear.
      if (rx_byte_valid && rx_byte_ready) begin
        rx_byte_valid <= 1'b0;
      end

      case (state)
        CFG: begin
          if (!csr.w_en) begin
            // Start a config attempt. This follows reset or a one-cycle retry gap.
            csr.w_en   <= 1'b1;
            csr.addr   <= CFG_ADDR;
            csr.w_data <= CFG_VALUE;
            tmo        <= '0;
          end else if (csr.ready) begin
            csr.w_en <= 1'b0;
            if (csr.slverr) begin
              err_cnt <= sat_inc(err_cnt);
            end else begin
              cfg_done      <= 1'b1;
              tx_byte_ready <= 1'b1;
              state         <= IDLE;
            end
          end else if (tmo_hit) begin
            csr.w_en <= 1'b0;
            err_cnt  <= sat_inc(err_cnt);
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        IDLE: begin
          if (interupt && !rx_byte_valid) begin
            // RX wins. A byte the host hands over on this same edge is still
            // accepted and parked in tx_hold, so it goes out after the read.
            csr.r_en      <= 1'b1;
            csr.addr      <= RX_ADDR;
            tmo           <= '0;
            tx_byte_ready <= 1'b0;
            state         <= RX_REQ;
            if (tx_byte_ready && tx_byte_valid) begin
              tx_hold <= tx_byte;
              tx_pend <= 1'b1;
            end
          end else if (tx_pend) begin
            // Reissue a parked or rejected byte.
            csr.w_en      <= 1'b1;
            csr.addr      <= TX_ADDR;
            csr.w_data    <= {24'h0, tx_hold};
            tmo           <= '0;
            tx_byte_ready <= 1'b0;
            state         <= TX_REQ;
          end else if (tx_byte_ready && tx_byte_valid) begin
            csr.w_en      <= 1'b1;
            csr.addr      <= TX_ADDR;
            csr.w_data    <= {24'h0, tx_byte};
            tx_hold       <= tx_byte;
            tx_pend       <= 1'b1;
            tmo           <= '0;
            tx_byte_ready <= 1'b0;
            state         <= TX_REQ;
          end
        end

        TX_REQ: begin
          if (csr.ready) begin
            csr.w_en <= 1'b0;
            state    <= IDLE;
            if (csr.slverr) begin
              // The TX FIFO rejected the byte. Keep it and retry after one idle cycle.
              err_cnt       <= sat_inc(err_cnt);
              tx_byte_ready <= 1'b0;
            end else begin
              tx_pend       <= 1'b0;
              tx_byte_ready <= 1'b1;
            end
          end else if (tmo_hit) begin
            // No answer from the UART. Drop the byte.
            csr.w_en      <= 1'b0;
            err_cnt       <= sat_inc(err_cnt);
            tx_pend       <= 1'b0;
            tx_byte_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        RX_REQ: begin
          if (csr.ready) begin
            csr.r_en      <= 1'b0;
            tx_byte_ready <= !tx_pend;
            state         <= IDLE;
            if (csr.slverr) begin
              err_cnt <= sat_inc(err_cnt);
            end else begin
              rx_byte       <= csr.r_data[7:0];
              rx_byte_valid <= 1'b1;
            end
          end else if (tmo_hit) begin
            csr.r_en      <= 1'b0;
            err_cnt       <= sat_inc(err_cnt);
            tx_byte_ready <= !tx_pend;
            state         <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        default: begin
          csr.w_en      <= 1'b0;
          csr.r_en      <= 1'b0;
          tx_byte_ready <= 1'b0;
          state         <= CFG;
        end
      endcase
    end
  end

  // Reads and writes never overlap.
  a_excl: assert property (@(posedge clk) disable iff (rst)
    !(csr.w_en && csr.r_en));

  // An open request keeps its fields until it completes or is aborted.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    ((csr.w_en || csr.r_en) && !csr.ready && !tmo_hit)
      |=> ((csr.w_en || csr.r_en) && $stable(csr.addr) && $stable(csr.w_data)));

  // Every completion is followed by at least one cycle with no request.
  a_gap: assert property (@(posedge clk) disable iff (rst)
    ((csr.w_en || csr.r_en) && csr.ready) |=> !(csr.w_en || csr.r_en));

  // The host may hand over a byte only while the sequencer is idle.
  a_txr: assert property (@(posedge clk) disable iff (rst)
    tx_byte_ready |-> (state == IDLE));

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master. Each task drives one scenario. The bench
// plays the UART CSR slave by hand and compares inline against hand-computed values.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_bus_master;

  localparam logic [31:0] CFG_ADDR  = 32'h0000_0000;
  localparam logic [31:0] TX_ADDR   = 32'h0000_0004;
  localparam logic [31:0] RX_ADDR   = 32'h0000_0008;
  localparam logic [31:0] CFG_VALUE = 32'hCAFE_0123;
  localparam int          TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_byte_valid = 1'b0;
  logic       tx_byte_ready;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_byte_ready = 1'b0;
  logic       interupt = 1'b0;
  logic       cfg_done;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_err = 8'h00;

  uart_bus_master_if bus ();

  uart_bus_master #(
    .CFG_ADDR  (CFG_ADDR),
    .TX_ADDR   (TX_ADDR),
    .RX_ADDR   (RX_ADDR),
    .CFG_VALUE (CFG_VALUE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_ready (tx_byte_ready),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte_ready (rx_byte_ready),
    .interupt      (interupt),
    .cfg_done      (cfg_done),
    .err_cnt       (err_cnt),
    .csr           (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Reset values of every output.
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({bus.w_en, bus.r_en} !== 2'b00) begin
      errors++; $display("FAIL reset_en got %b want 00", {bus.w_en, bus.r_en});
    end
    checks++;
    if ({bus.addr, bus.w_data} !== 64'h0) begin
      errors++; $display("FAIL reset_addr_wdata got %h %h want 0 0", bus.addr, bus.w_data);
    end
    checks++;
    if ({tx_byte_ready, rx_byte_valid, rx_byte} !== 10'h0) begin
      errors++; $display("FAIL reset_host got txr=%b rxv=%b rxb=%h want 0 0 00",
                         tx_byte_ready, rx_byte_valid, rx_byte);
    end
    checks++;
    if ({cfg_done, err_cnt} !== 9'h0) begin
      errors++; $display("FAIL reset_status got cfg_done=%b err=%h want 0 00", cfg_done, err_cnt);
    end
    rst = 1'b0;
  endtask

  // Config write: ready on the 2nd request cycle, cfg_done the cycle after.
  task automatic test_cfg_write();
    tick();
    checks++;
    if (!(bus.w_en === 1'b1 && bus.r_en === 1'b0 && bus.addr === CFG_ADDR && bus.w_data === CFG_VALUE)) begin
      errors++; $display("FAIL cfg_req got w=%b r=%b a=%h d=%h want 1 0 %h %h",
                         bus.w_en, bus.r_en, bus.addr, bus.w_data, CFG_ADDR, CFG_VALUE);
    end
    checks++;
    if (cfg_done !== 1'b0) begin
      errors++; $display("FAIL cfg_early got %b want 0", cfg_done);
    end
    tick();
    checks++;
    if (bus.w_en !== 1'b1) begin
      errors++; $display("FAIL cfg_hold got %b want 1", bus.w_en);
    end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    checks++;
    if (!(bus.w_en === 1'b0 && cfg_done === 1'b1 && tx_byte_ready === 1'b1 && err_cnt === 8'h00)) begin
      errors++; $display("FAIL cfg_done got w=%b done=%b txr=%b err=%h want 0 1 1 00",
                         bus.w_en, cfg_done, tx_byte_ready, err_cnt);
    end
  endtask

  // TX write with ready in the 3rd request cycle.
  task automatic test_tx_write();
    int bad = 0;
    tx_byte = 8'hA5;
    tx_byte_valid = 1'b1;
    tick();
    tx_byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!(bus.w_en === 1'b1 && bus.r_en === 1'b0 && bus.addr === TX_ADDR &&
            bus.w_data === 32'h0000_00A5 && tx_byte_ready === 1'b0)) bad++;
      if (i == 2) bus.ready = 1'b1;
      tick();
    end
    bus.ready = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL tx_req_cycles got %0d bad cycles want 0", bad);
    end
    checks++;
    if (!(bus.w_en === 1'b0 && tx_byte_ready === 1'b1 && err_cnt === exp_err)) begin
      errors++; $display("FAIL tx_done got w=%b txr=%b err=%h want 0 1 %h",
                         bus.w_en, tx_byte_ready, err_cnt, exp_err);
    end
  endtask

  // Interrupt and TX byte in the same IDLE cycle: the read goes first, then the write.
  task automatic test_rx_priority();
    interupt = 1'b1;
    tx_byte = 8'h3C;
    tx_byte_valid = 1'b1;
    tick();
    tx_byte_valid = 1'b0;
    interupt = 1'b0;
    checks++;
    if (!(bus.r_en === 1'b1 && bus.w_en === 1'b0 && bus.addr === RX_ADDR && tx_byte_ready === 1'b0)) begin
      errors++; $display("FAIL prio_read got r=%b w=%b a=%h txr=%b want 1 0 %h 0",
                         bus.r_en, bus.w_en, bus.addr, tx_byte_ready, RX_ADDR);
    end
    bus.r_data = 32'h0000_005A;
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    bus.r_data = 32'h0;
    checks++;
    if (!(rx_byte_valid === 1'b1 && rx_byte === 8'h5A && bus.r_en === 1'b0 && bus.w_en === 1'b0)) begin
      errors++; $display("FAIL prio_rx got v=%b b=%h r=%b w=%b want 1 5a 0 0",
                         rx_byte_valid, rx_byte, bus.r_en, bus.w_en);
    end
    tick();
    checks++;
    if (!(bus.w_en === 1'b1 && bus.addr === TX_ADDR && bus.w_data === 32'h0000_003C)) begin
      errors++; $display("FAIL prio_tx got w=%b a=%h d=%h want 1 %h 0000003c",
                         bus.w_en, bus.addr, bus.w_data, TX_ADDR);
    end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    checks++;
    if (!(bus.w_en === 1'b0 && tx_byte_ready === 1'b1)) begin
      errors++; $display("FAIL prio_tx_done got w=%b txr=%b want 0 1", bus.w_en, tx_byte_ready);
    end
  endtask

  // A held interrupt with the host not accepting gives exactly one read.
  task automatic test_rx_hold();
    int reads = 0;
    interupt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.r_en) reads++;
      tick();
    end
    checks++;
    if (!(reads == 0 && rx_byte_valid === 1'b1 && rx_byte === 8'h5A)) begin
      errors++; $display("FAIL hold_pending got reads=%0d v=%b b=%h want 0 1 5a",
                         reads, rx_byte_valid, rx_byte);
    end
    rx_byte_ready = 1'b1;
    tick();
    rx_byte_ready = 1'b0;
    checks++;
    if (rx_byte_valid !== 1'b0) begin
      errors++; $display("FAIL hold_accept got %b want 0", rx_byte_valid);
    end
    bus.r_data = 32'hFFFF_FF77;
    for (int i = 0; i < 12; i++) begin
      if (bus.r_en) begin
        reads++;
        bus.ready = 1'b1;
      end else begin
        bus.ready = 1'b0;
      end
      tick();
    end
    bus.ready = 1'b0;
    checks++;
    if (!(reads == 1 && rx_byte_valid === 1'b1 && rx_byte === 8'h77)) begin
      errors++; $display("FAIL hold_one_read got reads=%0d v=%b b=%h want 1 1 77",
                         reads, rx_byte_valid, rx_byte);
    end
    interupt = 1'b0;
    rx_byte_ready = 1'b1;
    tick();
    rx_byte_ready = 1'b0;
    checks++;
    if (!(rx_byte_valid === 1'b0 && bus.r_en === 1'b0)) begin
      errors++; $display("FAIL hold_release got v=%b r=%b want 0 0", rx_byte_valid, bus.r_en);
    end
  endtask

  // A read answered with slverr delivers no byte and counts one error.
  task automatic test_rx_error();
    interupt = 1'b1;
    tick();
    interupt = 1'b0;
    checks++;
    if (bus.r_en !== 1'b1) begin
      errors++; $display("FAIL rxerr_req got %b want 1", bus.r_en);
    end
    bus.r_data = 32'h0000_0099;
    bus.ready = 1'b1;
    bus.slverr = 1'b1;
    tick();
    bus.ready = 1'b0;
    bus.slverr = 1'b0;
    exp_err = exp_err + 8'd1;
    checks++;
    if (!(bus.r_en === 1'b0 && rx_byte_valid === 1'b0 && err_cnt === exp_err)) begin
      errors++; $display("FAIL rxerr_done got r=%b v=%b err=%h want 0 0 %h",
                         bus.r_en, rx_byte_valid, err_cnt, exp_err);
    end
  endtask

  // A TX write that is never answered stays up for exactly TIMEOUT cycles.
  task automatic test_timeout();
    int n = 0;
    int quiet = 0;
    tx_byte = 8'hC3;
    tx_byte_valid = 1'b1;
    tick();
    tx_byte_valid = 1'b0;
    while (bus.w_en && n < 40) begin
      n++;
      tick();
    end
    exp_err = exp_err + 8'd1;
    checks++;
    if (n != TIMEOUT) begin
      errors++; $display("FAIL tmo_len got %0d cycles want %0d", n, TIMEOUT);
    end
    checks++;
    if (!(err_cnt === exp_err && tx_byte_ready === 1'b1)) begin
      errors++; $display("FAIL tmo_status got err=%h txr=%b want %h 1", err_cnt, tx_byte_ready, exp_err);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.w_en || bus.r_en) quiet++;
      tick();
    end
    checks++;
    if (quiet != 0) begin
      errors++; $display("FAIL tmo_dropped got %0d request cycles want 0", quiet);
    end
  endtask

  // A TX slverr reissues the same byte after one idle cycle. An async reset
  // mid-request drops en at once and the block restarts in CFG.
  task automatic test_slverr_and_reset();
    int n = 0;
    int quiet = 0;
    tx_byte = 8'h96;
    tx_byte_valid = 1'b1;
    tick();
    tx_byte_valid = 1'b0;
    checks++;
    if (!(bus.w_en === 1'b1 && bus.w_data === 32'h0000_0096)) begin
      errors++; $display("FAIL slv_req got w=%b d=%h want 1 00000096", bus.w_en, bus.w_data);
    end
    bus.ready = 1'b1;
    bus.slverr = 1'b1;
    tick();
    bus.ready = 1'b0;
    bus.slverr = 1'b0;
    exp_err = exp_err + 8'd1;
    checks++;
    if (!(bus.w_en === 1'b0 && err_cnt === exp_err && tx_byte_ready === 1'b0)) begin
      errors++; $display("FAIL slv_gap got w=%b err=%h txr=%b want 0 %h 0",
                         bus.w_en, err_cnt, tx_byte_ready, exp_err);
    end
    tick();
    checks++;
    if (!(bus.w_en === 1'b1 && bus.addr === TX_ADDR && bus.w_data === 32'h0000_0096)) begin
      errors++; $display("FAIL slv_reissue got w=%b a=%h d=%h want 1 %h 00000096",
                         bus.w_en, bus.addr, bus.w_data, TX_ADDR);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!(bus.w_en === 1'b0 && cfg_done === 1'b0 && err_cnt === 8'h00)) begin
      errors++; $display("FAIL async_rst got w=%b done=%b err=%h want 0 0 00", bus.w_en, cfg_done, err_cnt);
    end
    exp_err = 8'h00;
    tick();
    rst = 1'b0;
    while (!bus.w_en && n < 5) begin
      n++;
      tick();
    end
    checks++;
    if (!(bus.w_en === 1'b1 && bus.addr === CFG_ADDR && bus.w_data === CFG_VALUE)) begin
      errors++; $display("FAIL rst_cfg got w=%b a=%h d=%h want 1 %h %h",
                         bus.w_en, bus.addr, bus.w_data, CFG_ADDR, CFG_VALUE);
    end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.w_en || bus.r_en) quiet++;
      tick();
    end
    checks++;
    if (!(cfg_done === 1'b1 && quiet == 0 && tx_byte_ready === 1'b1)) begin
      errors++; $display("FAIL rst_byte_lost got done=%b req_cycles=%0d txr=%b want 1 0 1",
                         cfg_done, quiet, tx_byte_ready);
    end
  endtask

  // CFG retries on slverr with a one-cycle en gap. The error count saturates at FF.
  task automatic test_err_sat();
    int miss = 0;
    int gap_bad = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 260; k++) begin
      for (int j = 0; j < 4 && !bus.w_en; j++) tick();
      if (!bus.w_en) begin
        miss++;
        break;
      end
      bus.ready = 1'b1;
      bus.slverr = 1'b1;
      tick();
      bus.ready = 1'b0;
      bus.slverr = 1'b0;
      if (bus.w_en) gap_bad++;
    end
    checks++;
    if (!(miss == 0 && gap_bad == 0)) begin
      errors++; $display("FAIL sat_retry got missing=%0d no_gap=%0d want 0 0", miss, gap_bad);
    end
    checks++;
    if (!(err_cnt === 8'hFF && cfg_done === 1'b0)) begin
      errors++; $display("FAIL sat_value got err=%h done=%b want ff 0", err_cnt, cfg_done);
    end
    tick();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    checks++;
    if (!(cfg_done === 1'b1 && err_cnt === 8'hFF)) begin
      errors++; $display("FAIL sat_cfg_ok got done=%b err=%h want 1 ff", cfg_done, err_cnt);
    end
  endtask

  initial begin
    bus.ready  = 1'b0;
    bus.slverr = 1'b0;
    bus.r_data = 32'h0;
    test_reset();
    test_cfg_write();
    test_tx_write();
    test_rx_priority();
    test_rx_hold();
    test_rx_error();
    test_timeout();
    test_slverr_and_reset();
    test_err_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
